fp_itof_sequencer: RTL and testbench

FP_ITOF_SEQUENCER -- requirements
Module: fp_itof_sequencer

---
 rtl/fp_itof_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_fp_itof_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_itof_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fp_itof_sequencer (with package fp_itof_defines_pkg)
//  Purpose  : Lane-serial signed int32 -> IEEE-754 single conversion of a
//             16-lane vector, one lane per cycle, round-to-nearest-even.
//  Option   : FP_ITOF_SKIP_MASKED_EN - when defined, the lane counter jumps
//             straight between enabled lanes so CONVERT lasts popcount(mask)
//             cycles, and an all-zero mask goes directly to DONE.
//  Revision : 1.0 - initial release
// ============================================================================

package fp_itof_defines_pkg;
  localparam int NUM_VECTOR_LANES = 16;
  localparam int THREAD_IDX_W     = 2;
  typedef logic [THREAD_IDX_W-1:0]     local_thread_idx_t;
  typedef logic [NUM_VECTOR_LANES-1:0] vector_mask_t;
  typedef logic [31:0]                 scalar_t;
endpackage

module fp_itof_sequencer
  import fp_itof_defines_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [THREAD_IDX_W-1:0]           req_thread_idx,
  input  logic [NUM_VECTOR_LANES-1:0]       req_mask,
  input  logic [NUM_VECTOR_LANES-1:0][31:0] req_operand,
  output logic                              result_valid,
  input  logic                              result_ack,
  output logic [THREAD_IDX_W-1:0]           result_thread_idx,
  output logic [NUM_VECTOR_LANES-1:0]       result_mask,
  output logic [NUM_VECTOR_LANES-1:0][31:0] result_value
);

  localparam int LANE_W = $clog2(NUM_VECTOR_LANES);
  localparam logic [LANE_W-1:0] c_LAST_LANE = LANE_W'(NUM_VECTOR_LANES - 1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_CONVERT = 2'd1;
  localparam logic [1:0] c_DONE    = 2'd2;

  logic [1:0]                        state_q, state_d;
  logic [LANE_W-1:0]                 lane_q;
  logic [NUM_VECTOR_LANES-1:0][31:0] operand_q;
  logic [NUM_VECTOR_LANES-1:0][31:0] value_q;
  logic [NUM_VECTOR_LANES-1:0]       mask_q;
  logic [THREAD_IDX_W-1:0]           tag_q;

  logic              accept;
  logic              first_found;
  logic [LANE_W-1:0] first_lane;
  logic              last_lane;
  logic [LANE_W-1:0] next_lane;

  // Conversion datapath signals
  logic [31:0] cur_op;
  logic        sign;
  logic [31:0] mag;
  logic [5:0]  lz;
  logic [31:0] norm;
  logic [7:0]  exp_raw;
  logic [22:0] mant_raw;
  logic        guard, rnd, sticky, round_up;
  logic [23:0] mant_sum;
  logic [7:0]  exp_fin;
  logic [22:0] mant_fin;
  logic [31:0] conv_value;

  assign accept = req_valid && (state_q == c_IDLE);

`ifdef FP_ITOF_SKIP_MASKED_EN
  // Lowest enabled lane at or above 'start'; MSB of the result flags a hit.
  function automatic logic [LANE_W:0] find_lane(input logic [NUM_VECTOR_LANES-1:0] mask,
                                                input logic [LANE_W:0]           start);
    logic [LANE_W:0] res;
    res = '0;
    for (int i = NUM_VECTOR_LANES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(start))) res = {1'b1, LANE_W'(i)};
    end
    return res;
  endfunction

  logic [LANE_W:0] first_sel, next_sel;

  // Lane sequencing: hop between enabled lanes only
  always_comb begin
    first_sel   = find_lane(req_mask, '0);
    next_sel    = find_lane(mask_q, {1'b0, lane_q} + 1'b1);
    first_found = first_sel[LANE_W];
    first_lane  = first_sel[LANE_W-1:0];
    last_lane   = !next_sel[LANE_W];
    next_lane   = next_sel[LANE_W-1:0];
  end
`else
  // Lane sequencing: visit every lane so latency is fixed
  always_comb begin
    first_found = 1'b1;
    first_lane  = '0;
    last_lane   = (lane_q == c_LAST_LANE);
    next_lane   = lane_q + 1'b1;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= c_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:    if (accept) state_d = first_found ? c_CONVERT : c_DONE;
      c_CONVERT: if (last_lane) state_d = c_DONE;
      c_DONE:    if (result_ack) state_d = c_IDLE;
      default:   state_d = c_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready    = (state_q == c_IDLE);
    result_valid = (state_q == c_DONE);
  end

  // Convert the operand of the lane currently addressed by the counter
  always_comb begin
    cur_op = operand_q[lane_q];
    sign   = cur_op[31];
    // Two's-complement negate; 0x80000000 maps to 2^31 as unsigned
    mag    = sign ? (~cur_op + 32'd1) : cur_op;
    lz     = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) lz = 6'(31 - i);
    end
    // A zero magnitude shifts out to all zeros, so norm[31] doubles as nonzero flag
    norm     = mag << lz;
    exp_raw  = 8'd158 - {2'b00, lz};
    mant_raw = norm[30:8];
    guard    = norm[7];
    rnd      = norm[6];
    sticky   = |norm[5:0];
    round_up = guard & (rnd | sticky | mant_raw[0]);
    mant_sum = {1'b0, mant_raw} + {23'd0, round_up};
    if (mant_sum[23]) begin
      exp_fin  = exp_raw + 8'd1;
      mant_fin = '0;
    end else begin
      exp_fin  = exp_raw;
      mant_fin = mant_sum[22:0];
    end
    conv_value = norm[31] ? {sign, exp_fin, mant_fin} : 32'd0;
  end

  // Request capture and per-lane result write-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q    <= '0;
      operand_q <= '0;
      value_q   <= '0;
      mask_q    <= '0;
      tag_q     <= '0;
    end else if (accept) begin
      lane_q    <= first_lane;
      operand_q <= req_operand;
      value_q   <= '0;
      mask_q    <= req_mask;
      tag_q     <= req_thread_idx;
    end else if (state_q == c_CONVERT) begin
      // Disabled lanes keep the zero written at accept
      if (mask_q[lane_q]) value_q[lane_q] <= conv_value;
      if (!last_lane) lane_q <= next_lane;
    end
  end

  assign result_value      = value_q;
  assign result_mask       = mask_q;
  assign result_thread_idx = tag_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_itof_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_itof_sequencer
//  Purpose  : Self-checking bench for fp_itof_sequencer: directed vector
//             table, hand-written backpressure/reset sequences and random
//             requests against an arithmetic reference model.
//  Option   : FP_ITOF_SKIP_MASKED_EN changes the expected latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_itof_sequencer;
  import fp_itof_defines_pkg::*;

  typedef logic [NUM_VECTOR_LANES-1:0][31:0] lanes_t;
  typedef struct {
    logic [15:0] mask;
    lanes_t      ops;
    lanes_t      expv;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [THREAD_IDX_W-1:0] req_thread_idx = '0;
  logic [15:0] req_mask = '0;
  lanes_t      req_operand = '0;
  logic        result_valid;
  logic        result_ack = 1'b0;
  logic [THREAD_IDX_W-1:0] result_thread_idx;
  logic [15:0] result_mask;
  lanes_t      result_value;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t tbl [3];

  fp_itof_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_thread_idx    (req_thread_idx),
    .req_mask          (req_mask),
    .req_operand       (req_operand),
    .result_valid      (result_valid),
    .result_ack        (result_ack),
    .result_thread_idx (result_thread_idx),
    .result_mask       (result_mask),
    .result_value      (result_value)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  // Reference conversion: exact value, then round the integer quotient to
  // 24 significant bits by comparing the discarded remainder with one half.
  function automatic logic [31:0] ref_itof(input logic [31:0] v);
    longint mag, q, rem, half;
    int     e, sh;
    logic   s;
    if (v == 32'd0) return 32'd0;
    s   = v[31];
    mag = longint'($signed(v));
    if (mag < 0) mag = -mag;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = mag << (23 - e);
    end else begin
      sh   = e - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'sd1 << (sh - 1);
      if ((rem > half) || ((rem == half) && (q % 2 == 1))) q = q + 1;
      if (q == (64'sd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {s, 8'(e + 127), 23'(q)};
  endfunction

  function automatic lanes_t model_vec(input logic [15:0] m, input lanes_t ops);
    lanes_t r;
    for (int k = 0; k < 16; k++) r[k] = m[k] ? ref_itof(ops[k]) : 32'd0;
    return r;
  endfunction

  function automatic int exp_latency(input logic [15:0] m);
`ifdef FP_ITOF_SKIP_MASKED_EN
    int pc;
    pc = 0;
    for (int k = 0; k < 16; k++) pc += int'(m[k]);
    return pc + 1;
`else
    return (m == m) ? 17 : 17;
`endif
  endfunction

  // Present one request and wait (bounded) for result_valid.
  task automatic issue(input logic [15:0] m, input lanes_t ops, input logic [1:0] tag,
                       input bit early_ack, output int cyc);
    int w;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid      = 1'b1;
    req_mask       = m;
    req_operand    = ops;
    req_thread_idx = tag;
    result_ack     = early_ack;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!result_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_result(input string nm, input logic [15:0] m, input logic [1:0] tag,
                              input lanes_t expv, input int cyc);
    check({nm, "_latency"}, 32'(cyc), 32'(exp_latency(m)));
    check({nm, "_valid"}, {31'd0, result_valid}, 32'd1);
    check({nm, "_ready_low"}, {31'd0, req_ready}, 32'd0);
    check({nm, "_mask"}, {16'd0, result_mask}, {16'd0, m});
    check({nm, "_tag"}, {30'd0, result_thread_idx}, {30'd0, tag});
    for (int k = 0; k < 16; k++)
      check($sformatf("%s_lane%0d", nm, k), result_value[k], expv[k]);
  endtask

  task automatic do_ack(input string nm);
    @(negedge clk);
    result_ack = 1'b1;
    @(posedge clk); #1;
    result_ack = 1'b0;
    check({nm, "_ready_after_ack"}, {31'd0, req_ready}, 32'd1);
    check({nm, "_valid_after_ack"}, {31'd0, result_valid}, 32'd0);
  endtask

  initial begin
    int     cyc;
    lanes_t ops, expv;
    logic [15:0] m;
    logic [1:0]  tag;

    // Directed vector table
    for (int i = 0; i < 3; i++) begin
      tbl[i].ops  = '0;
      tbl[i].expv = '0;
    end
    tbl[0].mask = 16'hFFFF;
    tbl[0].ops[0] = 32'd1;          tbl[0].expv[0] = 32'h3F800000;
    tbl[0].ops[1] = 32'hFFFFFFFF;   tbl[0].expv[1] = 32'hBF800000;
    tbl[0].ops[2] = 32'd0;          tbl[0].expv[2] = 32'h00000000;
    tbl[0].ops[3] = 32'h80000000;   tbl[0].expv[3] = 32'hCF000000;
    tbl[0].ops[4] = 32'h7FFFFFFF;   tbl[0].expv[4] = 32'h4F000000;
    tbl[1].mask = 16'hFFFF;
    tbl[1].ops[0] = 32'd16777217;   tbl[1].expv[0] = 32'h4B800000;
    tbl[1].ops[1] = 32'd16777219;   tbl[1].expv[1] = 32'h4B800002;
    tbl[1].ops[2] = 32'h01FFFFFF;   tbl[1].expv[2] = 32'h4C000000;
    tbl[2].mask = 16'h0005;
    tbl[2].ops[0] = 32'd5;          tbl[2].expv[0] = 32'h40A00000;
    tbl[2].ops[1] = 32'd7;
    tbl[2].ops[2] = 32'hFFFFFFFD;   tbl[2].expv[2] = 32'hC0400000;
    tbl[2].ops[3] = 32'd9;

    // Reset state
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_mask", {16'd0, result_mask}, 32'd0);
    check("rst_tag", {30'd0, result_thread_idx}, 32'd0);
    check("rst_value0", result_value[0], 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Table-driven directed vectors; first accept lands on the first edge
    for (int i = 0; i < 3; i++) begin
      issue(tbl[i].mask, tbl[i].ops, 2'(i + 1), 1'b0, cyc);
      check_result($sformatf("tbl%0d", i), tbl[i].mask, 2'(i + 1), tbl[i].expv, cyc);
      do_ack($sformatf("tbl%0d", i));
    end

    // Backpressure: hold ack low, inject a stray request, outputs must not move
    issue(tbl[2].mask, tbl[2].ops, 2'd3, 1'b0, cyc);
    check_result("bp", tbl[2].mask, 2'd3, tbl[2].expv, cyc);
    for (int h = 0; h < 10; h++) begin
      @(negedge clk);
      if (h == 3) begin
        req_valid      = 1'b1;
        req_mask       = 16'hFFFF;
        req_operand    = tbl[0].ops;
        req_thread_idx = 2'd0;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", h), {31'd0, result_valid}, 32'd1);
      check($sformatf("bp_hold%0d_stable", h),
            {31'd0, (result_value == tbl[2].expv) && (result_mask == 16'h0005)
                    && (result_thread_idx == 2'd3)}, 32'd1);
    end
    req_valid = 1'b0;
    do_ack("bp");

    // Reset in the middle of a conversion
    @(negedge clk);
    req_valid   = 1'b1;
    req_mask    = 16'hFFFF;
    req_operand = tbl[1].ops;
    req_thread_idx = 2'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_valid", {31'd0, result_valid}, 32'd0);
    check("midrst_value0", result_value[0], 32'd0);
    check("midrst_mask", {16'd0, result_mask}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    issue(tbl[0].mask, tbl[0].ops, 2'd1, 1'b0, cyc);
    check_result("postrst", tbl[0].mask, 2'd1, tbl[0].expv, cyc);
    do_ack("postrst");

`ifdef FP_ITOF_SKIP_MASKED_EN
    ops = tbl[0].ops;
    ops[15] = 32'hFFFFFF00;
    issue(16'h0000, ops, 2'd0, 1'b0, cyc);
    check_result("skip0", 16'h0000, 2'd0, model_vec(16'h0000, ops), cyc);
    do_ack("skip0");
    issue(16'h8001, ops, 2'd1, 1'b0, cyc);
    check_result("skip8001", 16'h8001, 2'd1, model_vec(16'h8001, ops), cyc);
    do_ack("skip8001");
`endif

    // Randomized requests against the reference model
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       m = 16'h0000;
        1:       m = 16'hFFFF;
        default: m = 16'($urandom);
      endcase
      for (int k = 0; k < 16; k++) begin
        case ($urandom_range(0, 5))
          0:       ops[k] = 32'd0;
          1:       ops[k] = 32'h80000000;
          2:       ops[k] = 32'h7FFFFFFF;
          3:       ops[k] = 32'($signed($urandom_range(0, 255)) - 128);
          4:       ops[k] = 32'($urandom_range(0, 32'h03FFFFFF)) | 32'h01000000;
          default: ops[k] = $urandom;
        endcase
      end
      tag  = 2'($urandom);
      expv = model_vec(m, ops);
      issue(m, ops, tag, (i % 3) == 1, cyc);
      check_result($sformatf("rnd%0d", i), m, tag, expv, cyc);
      do_ack($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
